spike_sequencer: RTL and testbench



---
 rtl/spike_pkg.sv | 30 +++
 rtl/spike_group_fsm.sv | 71 +++++++
 rtl/spike_sequencer.sv | 96 +++++++++
 tb/tb_spike_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Step-type codes, phase encoding and the phase-to-step mapping shared by the
// spike sequencer and its per-group FSMs.
package spike_pkg;

  localparam logic [2:0] STEP_FREE  = 3'd0;
  localparam logic [2:0] STEP_REGU  = 3'd1;
  localparam logic [2:0] STEP_GATE  = 3'd2;
  localparam logic [2:0] STEP_DEATH = 3'd3;
  localparam logic [2:0] STEP_WALL  = 3'd4;
  localparam logic [2:0] STEP_SPIKE = 3'd5;

  typedef enum logic [1:0] {
    PH_HIDDEN = 2'd0,
    PH_WARN   = 2'd1,
    PH_ACTIVE = 2'd2
  } phase_e;

  // Step drawn for a SPIKE tile given its group's phase and blink state.
  function automatic logic [2:0] spike_step(phase_e ph, logic blink_on);
    logic [2:0] step;
    step = STEP_FREE;
    case (ph)
      PH_WARN:   step = blink_on ? STEP_SPIKE : STEP_FREE;
      PH_ACTIVE: step = STEP_SPIKE;
      default:   step = STEP_FREE;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/spike_group_fsm.sv
// One column-parity group: HIDDEN -> WARN -> ACTIVE cycle timed in frames,
// with a blink phase for the warning and a one-cycle change pulse.
//
// state     | meaning
// PH_HIDDEN | spikes retracted, drawn as FREE
// PH_WARN   | spikes blinking, harmless
// PH_ACTIVE | spikes extended and lethal
module spike_group_fsm
  import spike_pkg::*;
#(
  parameter int unsigned HIDDEN_FRAMES = 90,
  parameter int unsigned WARN_FRAMES   = 32,
  parameter int unsigned ACTIVE_FRAMES = 60,
  parameter int unsigned BLINK_LOG2    = 2,
  parameter phase_e      RESET_PHASE   = PH_HIDDEN
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       adv,
  output logic [1:0] phase,
  output logic       blink_on,
  output logic       changed
);

  phase_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] last_cnt;
  logic       changed_q, changed_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= RESET_PHASE;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    case (state_q)
      PH_WARN:   last_cnt = 8'(WARN_FRAMES - 1);
      PH_ACTIVE: last_cnt = 8'(ACTIVE_FRAMES - 1);
      default:   last_cnt = 8'(HIDDEN_FRAMES - 1);
    endcase
    if (adv) begin
      if (cnt_q == last_cnt) begin
        cnt_d     = '0;
        changed_d = 1'b1;
        case (state_q)
          PH_HIDDEN: state_d = PH_WARN;
          PH_WARN:   state_d = PH_ACTIVE;
          default:   state_d = PH_HIDDEN;
        endcase
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign phase    = state_q;
  // Low counter values start the warning visible.
  assign blink_on = ~cnt_q[BLINK_LOG2];
  assign changed  = changed_q;

endmodule

// File: rtl/spike_sequencer.sv
// Rewrites SPIKE tile step types per pixel from two out-of-phase group FSMs
// and qualifies player/spike collisions into one death pulse per frame.
module spike_sequencer
  import spike_pkg::*;
#(
  parameter int unsigned HIDDEN_FRAMES = 90,
  parameter int unsigned WARN_FRAMES   = 32,
  parameter int unsigned ACTIVE_FRAMES = 60,
  parameter int unsigned BLINK_LOG2    = 2,
  parameter int unsigned NUM_OF_COLS   = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic [2:0] tile_type_in,
  input  logic [3:0] tile_col,
  input  logic       collision,
  input  logic [3:0] collision_col,
  output logic [2:0] step_type_out,
  output logic [3:0] group_phase,
  output logic       phase_change,
  output logic       death_pulse
);

  localparam logic [4:0] NUM_COLS = 5'(NUM_OF_COLS);

  logic       adv;
  logic [1:0] phase0, phase1;
  logic       blink0, blink1;
  logic       changed0, changed1;
  logic [1:0] tile_phase, hit_phase;
  logic       tile_blink;
  logic [2:0] step_q, step_d;
  logic       death_q, death_d;
  logic       sent_q, sent_d;

  assign adv = startOfFrame & enable;

  spike_group_fsm #(
    .HIDDEN_FRAMES(HIDDEN_FRAMES), .WARN_FRAMES(WARN_FRAMES),
    .ACTIVE_FRAMES(ACTIVE_FRAMES), .BLINK_LOG2(BLINK_LOG2),
    .RESET_PHASE(PH_HIDDEN)
  ) u_group0 (
    .clk(clk), .resetN(resetN), .adv(adv),
    .phase(phase0), .blink_on(blink0), .changed(changed0)
  );

  spike_group_fsm #(
    .HIDDEN_FRAMES(HIDDEN_FRAMES), .WARN_FRAMES(WARN_FRAMES),
    .ACTIVE_FRAMES(ACTIVE_FRAMES), .BLINK_LOG2(BLINK_LOG2),
    .RESET_PHASE(PH_ACTIVE)
  ) u_group1 (
    .clk(clk), .resetN(resetN), .adv(adv),
    .phase(phase1), .blink_on(blink1), .changed(changed1)
  );

  always_comb begin
    tile_phase = tile_col[0] ? phase1 : phase0;
    tile_blink = tile_col[0] ? blink1 : blink0;
    hit_phase  = collision_col[0] ? phase1 : phase0;

    step_d = tile_type_in;
    if ({1'b0, tile_col} >= NUM_COLS) begin
      step_d = STEP_FREE;
    end else if (tile_type_in == STEP_SPIKE) begin
      step_d = spike_step(phase_e'(tile_phase), tile_blink);
    end

    // A hit on the frame boundary sees the old phase and a cleared flag.
    death_d = collision & enable & ({1'b0, collision_col} < NUM_COLS) &
              (hit_phase == PH_ACTIVE) & (~sent_q | startOfFrame);

    sent_d = sent_q;
    if (startOfFrame) sent_d = 1'b0;
    if (death_d)      sent_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      step_q  <= STEP_FREE;
      death_q <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      step_q  <= step_d;
      death_q <= death_d;
      sent_q  <= sent_d;
    end
  end

  assign step_type_out = step_q;
  assign group_phase   = {phase1, phase0};
  assign phase_change  = changed0 | changed1;
  assign death_pulse   = death_q;

endmodule

// File: tb/tb_spike_sequencer.sv
// Self-checking bench for spike_sequencer: behavioural group model, pixel
// scoreboard queue, a WARN-phase vector table and hand-written corner cases.
module tb_spike_sequencer;

  localparam int H  = 90;
  localparam int W  = 32;
  localparam int A  = 60;
  localparam int NC = 10;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] tile_type_in = 3'd0;
  logic [3:0] tile_col = 4'd0;
  logic       collision = 1'b0;
  logic [3:0] collision_col = 4'd0;
  logic [2:0] step_type_out;
  logic [3:0] group_phase;
  logic       phase_change;
  logic       death_pulse;

  always #5 clk = ~clk;

  spike_sequencer #(
    .HIDDEN_FRAMES(H), .WARN_FRAMES(W), .ACTIVE_FRAMES(A),
    .BLINK_LOG2(2), .NUM_OF_COLS(NC)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .tile_type_in(tile_type_in), .tile_col(tile_col),
    .collision(collision), .collision_col(collision_col),
    .step_type_out(step_type_out), .group_phase(group_phase),
    .phase_change(phase_change), .death_pulse(death_pulse)
  );

  typedef struct {
    int ty;
    int col;
    int exp_vis;
    int exp_dark;
  } vec_t;

  vec_t tbl[9];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_ph[2];
  int   m_cnt[2];
  bit   m_sent;
  int   exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: frame budget exhausted (t=%0t)", name, $time);
  endtask

  function automatic int dur(input int ph);
    if (ph == 1) return W;
    if (ph == 2) return A;
    return H;
  endfunction

  function automatic int model_step(input int ty, input int col);
    bit blink;
    if (col >= NC) return 0;
    if (ty != 5) return ty;
    blink = ((m_cnt[col % 2] / 4) % 2) == 0;
    if (m_ph[col % 2] == 2) return 5;
    if (m_ph[col % 2] == 1 && blink) return 5;
    return 0;
  endfunction

  task automatic model_frame(output bit t);
    t = 1'b0;
    for (int g = 0; g < 2; g++) begin
      if (m_cnt[g] == dur(m_ph[g]) - 1) begin
        m_ph[g]  = (m_ph[g] + 1) % 3;
        m_cnt[g] = 0;
        t = 1'b1;
      end else begin
        m_cnt[g]++;
      end
    end
  endtask

  task automatic model_reset();
    m_ph[0] = 0; m_ph[1] = 2;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_sent = 1'b0;
  endtask

  // One startOfFrame pulse, optionally with a simultaneous collision.
  task automatic frame(input bit with_hit, input int hcol);
    bit t;
    bit fire;
    @(negedge clk);
    startOfFrame = 1'b1;
    collision = with_hit;
    collision_col = hcol[3:0];
    fire = with_hit && enable && hcol < NC && m_ph[hcol % 2] == 2;
    t = 1'b0;
    if (enable) model_frame(t);
    m_sent = fire;
    @(posedge clk); #1;
    check("phase_change", phase_change, t);
    check("group_phase", group_phase, m_ph[1] * 4 + m_ph[0]);
    if (with_hit) check("death_on_sof", death_pulse, fire);
    @(negedge clk);
    startOfFrame = 1'b0;
    collision = 1'b0;
    @(posedge clk); #1;
    check("phase_change_clr", phase_change, 0);
  endtask

  task automatic hit(input int col, input string nm);
    bit fire;
    @(negedge clk);
    collision = 1'b1;
    collision_col = col[3:0];
    fire = enable && col < NC && m_ph[col % 2] == 2 && !m_sent;
    if (fire) m_sent = 1'b1;
    @(posedge clk); #1;
    check(nm, death_pulse, fire);
    @(negedge clk);
    collision = 1'b0;
    @(posedge clk); #1;
    check({nm, "_after"}, death_pulse, 0);
  endtask

  task automatic pixel(input int ty, input int col, input int exp);
    int e;
    @(negedge clk);
    tile_type_in = ty[2:0];
    tile_col = col[3:0];
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      bound_fail("step_queue_empty");
    end else begin
      e = exp_q.pop_front();
      check($sformatf("step t%0d c%0d", ty, col), step_type_out, e);
    end
  endtask

  initial begin
    int n;
    bit vis;

    tbl[0] = '{5, 4, 5, 0};
    tbl[1] = '{1, 4, 1, 1};
    tbl[2] = '{5, 3, 0, 0};
    tbl[3] = '{4, 3, 4, 4};
    tbl[4] = '{5, 12, 0, 0};
    tbl[5] = '{2, 12, 0, 0};
    tbl[6] = '{5, 0, 5, 0};
    tbl[7] = '{0, 8, 0, 0};
    tbl[8] = '{3, 7, 3, 3};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_group_phase", group_phase, 8);
    check("rst_step", step_type_out, 0);
    check("rst_phase_change", phase_change, 0);
    check("rst_death", death_pulse, 0);
    @(negedge clk);
    resetN = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    check("rel_phase_change", phase_change, 0);
    check("rel_group_phase", group_phase, 8);

    // Group1 starts ACTIVE: one kill per frame, even columns harmless.
    hit(3, "hit_first");
    hit(3, "hit_second");
    hit(2, "hit_even_hidden");
    frame(1'b0, 0);
    hit(11, "hit_col_out_of_range");
    hit(3, "hit_next_frame");
    hit(3, "hit_repeat");
    pixel(5, 3, 5);
    pixel(5, 2, 0);
    pixel(4, 12, 0);

    // Paused: no kill, drawing continues from frozen state.
    @(negedge clk);
    enable = 1'b0;
    repeat (3) frame(1'b0, 0);
    hit(3, "hit_disabled");
    pixel(5, 5, model_step(5, 5));
    @(negedge clk);
    enable = 1'b1;

    n = 0;
    while (!(m_ph[1] == 2 && m_cnt[1] == A - 1) && n < 200) begin
      frame(1'b0, 0);
      n++;
    end
    if (n >= 200) bound_fail("reach_last_active");
    hit(3, "hit_last_active");
    frame(1'b1, 3);
    hit(3, "hit_after_hide");

    n = 0;
    while (m_ph[0] != 1 && n < 200) begin
      frame(1'b0, 0);
      n++;
    end
    if (n >= 200) bound_fail("reach_warn");
    hit(2, "hit_warn_visible");

    for (int k = 0; k < 8; k++) begin
      vis = (m_cnt[0] % 8) < 4;
      foreach (tbl[i]) pixel(tbl[i].ty, tbl[i].col, vis ? tbl[i].exp_vis : tbl[i].exp_dark);
      frame(1'b0, 0);
    end

    @(negedge clk);
    enable = 1'b0;
    repeat (50) frame(1'b0, 0);
    hit(2, "hit_warn_frozen");
    pixel(5, 4, model_step(5, 4));
    @(negedge clk);
    enable = 1'b1;

    n = 0;
    while (m_ph[0] != 2 && n < 100) begin
      frame(1'b0, 0);
      n++;
    end
    if (n >= 100) bound_fail("reach_active");
    hit(2, "hit_g0_active");
    pixel(5, 6, model_step(5, 6));
    frame(1'b0, 0);
    frame(1'b0, 0);

    // Asynchronous reset mid-ACTIVE.
    @(negedge clk);
    tile_type_in = 3'd5;
    tile_col = 4'd4;
    resetN = 1'b0;
    model_reset();
    #1;
    check("async_rst_group_phase", group_phase, 8);
    check("async_rst_step", step_type_out, 0);
    check("async_rst_death", death_pulse, 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_phase_change", phase_change, 0);
      check("post_rst_death", death_pulse, 0);
      check("post_rst_group_phase", group_phase, 8);
      check("post_rst_step", step_type_out, 0);
    end
    pixel(5, 5, model_step(5, 5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
